backscatter_bit_scheduler: RTL and testbench

//   Sequences one backscatter frame: preamble bits, then a payload word, then a silent gap.

---
 rtl/backscatter_bit_scheduler.sv | 166 ++++++++++++++++
 tb/tb_backscatter_bit_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/backscatter_bit_scheduler.sv
// rtl/backscatter_bit_scheduler.sv - backscatter frame sequencer: preamble, payload, gap
module backscatter_bit_scheduler #(
    parameter int                       DIV_W            = 12,
    parameter int                       DEFAULT_DIV      = 10,
    parameter int                       PAYLOAD_W        = 32,
    parameter int                       PREAMBLE_BITS    = 8,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PATTERN = 8'hA7,
    parameter int                       GAP_TICKS        = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     div_value,
    input  logic                 cfg_load,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 busy,
    output logic                 done,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic                 tick,
    output logic                 start_drop
);

    localparam int FRAME_W = PREAMBLE_BITS + PAYLOAD_W;
    localparam int MAX_PG  = (PAYLOAD_W > GAP_TICKS) ? PAYLOAD_W : GAP_TICKS;
    localparam int MAX_LEN = (PREAMBLE_BITS > MAX_PG) ? PREAMBLE_BITS : MAX_PG;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BITS - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic                 done_next;
    logic [DIV_W-1:0]     counter;
    logic [DIV_W-1:0]     div_reg;
    logic [FRAME_W-1:0]   shift_reg;
    logic                 done_r;
    logic                 drop_r;
    logic                 accept;

    // A frame is accepted only from IDLE; this includes the done cycle.
    assign accept     = (state == IDLE) && start;
    assign busy       = (state != IDLE);
    assign bit_valid  = (state == PREAMBLE) || (state == PAYLOAD);
    assign tick       = busy && (counter == div_reg);
    assign bit_out    = bit_valid && shift_reg[FRAME_W-1];
    assign done       = done_r;
    assign start_drop = drop_r;

    // Next-state logic: each phase advances on the tick closing its last bit period.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = PREAMBLE;
                    bit_cnt_next = '0;
                end
            end
            PREAMBLE: begin
                if (tick) begin
                    if (bit_cnt == PRE_LAST) begin
                        state_next   = PAYLOAD;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
            end
            PAYLOAD: begin
                if (tick) begin
                    if (bit_cnt == PAY_LAST) begin
                        state_next   = GAP;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (bit_cnt == GAP_LAST) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                        done_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end
        endcase
    end

    // State, bit counter and the registered done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            done_r  <= done_next;
        end
    end

    // Bit-rate divider: period of div_reg+1 clocks, restarted on every accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else if (accept) begin
            counter <= '0;
        end else if (tick) begin
            counter <= '0;
        end else if (busy) begin
            counter <= counter + DIV_W'(1);
        end
    end

    // Divider config is frozen while a frame is in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_reg <= DIV_W'(DEFAULT_DIV);
        end else if (cfg_load && !busy) begin
            div_reg <= div_value;
        end
    end

    // Preamble and payload share one shifter so the payload MSB follows the preamble LSB.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (accept) begin
            shift_reg <= {PREAMBLE_PATTERN, payload};
        end else if (tick && bit_valid) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
        end
    end

    // Flag a start request that arrives while a frame is running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_r <= 1'b0;
        end else begin
            drop_r <= start && busy;
        end
    end

endmodule

// File: tb/tb_backscatter_bit_scheduler.sv
// tb/tb_backscatter_bit_scheduler.sv - scoreboard bench for backscatter_bit_scheduler
module tb_backscatter_bit_scheduler;

    localparam int NBITS  = 40;
    localparam int NTICKS = 44;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] div_value = '0;
    logic        cfg_load = 1'b0;
    logic        start = 1'b0;
    logic [31:0] payload = '0;
    logic        busy, done, bit_out, bit_valid, tick, start_drop;

    backscatter_bit_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .div_value  (div_value),
        .cfg_load   (cfg_load),
        .start      (start),
        .payload    (payload),
        .busy       (busy),
        .done       (done),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .tick       (tick),
        .start_drop (start_drop)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int   c;
        logic v;
        logic b;
    } tick_t;

    tick_t tick_q[$];
    int    done_q[$];
    int    drop_q[$];
    int    model_div = 10;
    int    busy_lo = 0;
    int    busy_hi = 0;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT events against the scoreboard queues
    always @(negedge clock) begin
        if (!reset) begin
            tick_t e;
            int    d;
            chk("busy", int'(busy), int'(cyc >= busy_lo && cyc < busy_hi));
            if (tick) begin
                if (tick_q.size() == 0) chk("tick_unexpected", int'(tick), 0);
                else begin
                    e = tick_q.pop_front();
                    chk("tick_cycle", cyc, e.c);
                    chk("tick_valid", int'(bit_valid), int'(e.v));
                    chk("tick_bit", int'(bit_out), int'(e.b));
                end
            end else if (tick_q.size() != 0 && cyc > tick_q[0].c) begin
                e = tick_q.pop_front();
                chk("tick_missing", cyc, e.c);
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", int'(done), 0);
                else begin
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d);
                end
            end else if (done_q.size() != 0 && cyc > done_q[0]) begin
                d = done_q.pop_front();
                chk("done_missing", cyc, d);
            end
            if (start_drop) begin
                if (drop_q.size() == 0) chk("drop_unexpected", int'(start_drop), 0);
                else begin
                    d = drop_q.pop_front();
                    chk("drop_cycle", cyc, d);
                end
            end else if (drop_q.size() != 0 && cyc > drop_q[0]) begin
                d = drop_q.pop_front();
                chk("drop_missing", cyc, d);
            end
        end
    end

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    // Issue a frame at the current negedge; the model derives every expected event.
    task automatic go(input logic [31:0] pl, input bit load, input int dv,
                      output int acc, output int dcyc);
        logic [NBITS-1:0] fr;
        int               per;
        start    = 1'b1;
        payload  = pl;
        cfg_load = load;
        div_value = 12'(dv);
        if (load) model_div = dv;
        per = model_div + 1;
        acc = cyc;
        fr  = {8'hA7, pl};
        for (int k = 0; k < NTICKS; k++) begin
            tick_t t;
            t.c = acc + (k + 1) * per;
            t.v = (k < NBITS);
            t.b = (k < NBITS) ? fr[NBITS-1-k] : 1'b0;
            tick_q.push_back(t);
        end
        dcyc = acc + 1 + NTICKS * per;
        done_q.push_back(dcyc);
        busy_lo = acc + 1;
        busy_hi = dcyc;
        @(negedge clock);
        start    = 1'b0;
        cfg_load = 1'b0;
    endtask

    // Start and cfg_load while busy: only start_drop is expected.
    task automatic poke(input int dv);
        start     = 1'b1;
        cfg_load  = 1'b1;
        div_value = 12'(dv);
        payload   = $urandom;
        drop_q.push_back(cyc + 1);
        @(negedge clock);
        start    = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic cfg_only(input int dv);
        cfg_load  = 1'b1;
        div_value = 12'(dv);
        model_div = dv;
        @(negedge clock);
        cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bit_out", int'(bit_out), 0);
        chk("rst_bit_valid", int'(bit_valid), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_start_drop", int'(start_drop), 0);
        tick_q.delete();
        done_q.delete();
        drop_q.delete();
        busy_hi   = 0;
        model_div = 10;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int acc, d, dv;
        bit load;
        do_reset();
        wait_to(cyc + 20);

        go(32'h8000_0001, 1'b0, 0, acc, d);
        chk("t2_latency", d - acc, 485);
        wait_to(d + 3);

        go($urandom, 1'b1, 0, acc, d);
        chk("t3_latency", d - acc, 45);
        wait_to(d + 2);

        go($urandom, 1'b1, 10, acc, d);
        wait_to(acc + 1 + 13 * 11 + 5);
        poke(3);
        wait_to(d);
        go($urandom, 1'b0, 0, acc, d);
        wait_to(d);
        go($urandom, 1'b0, 0, acc, d);
        wait_to(d + 2);

        cfg_only(1);
        wait_to(cyc + 2);
        for (int i = 0; i < 5; i++) begin
            load = 1'($urandom_range(0, 1));
            dv   = $urandom_range(0, 4);
            go($urandom, load, dv, acc, d);
            if ($urandom_range(0, 1) == 1) begin
                wait_to(acc + 5);
                poke($urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 1) wait_to(d);
            else wait_to(d + $urandom_range(1, 5));
        end

        go($urandom, 1'b1, 2, acc, d);
        wait_to(d - 5);
        do_reset();
        wait_to(cyc + 10);
        go($urandom, 1'b0, 0, acc, d);
        chk("t6_latency", d - acc, 485);
        wait_to(d + 5);

        chk("tick_q_drained", tick_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("drop_q_drained", drop_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: got no end expected finish before limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
